// File: rtl/mux8t1_32_if.sv
//------------------------------------------------------------------------------
// Module : mux8t1_32_if
// Brief  : Bus bundle for the 8:1 word selector (eight data words, select, out).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mux8t1_32_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] I0;
    logic [WIDTH-1:0] I1;
    logic [WIDTH-1:0] I2;
    logic [WIDTH-1:0] I3;
    logic [WIDTH-1:0] I4;
    logic [WIDTH-1:0] I5;
    logic [WIDTH-1:0] I6;
    logic [WIDTH-1:0] I7;
    logic [2:0]       s;
    logic [WIDTH-1:0] o;

    modport master (
        output I0, I1, I2, I3, I4, I5, I6, I7, s,
        input  o
    );

    modport slave (
        input  I0, I1, I2, I3, I4, I5, I6, I7, s,
        output o
    );
endinterface

`default_nettype wire

// File: rtl/mux8t1_32.sv
//------------------------------------------------------------------------------
// Module : mux8t1_32
// Brief  : Eight-way word selector with a single registered output stage.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mux8t1_32 #(
    parameter int WIDTH = 32
) (
    input  wire logic    clk,
    input  wire logic    rst,
    mux8t1_32_if.slave   bus
);

    logic [WIDTH-1:0] w_sel_word;
    logic [WIDTH-1:0] r_o;

    // All eight codes are decoded explicitly, so there is no fall-through value.
    always_comb begin
        w_sel_word = bus.I0;
        case (bus.s)
            3'd0: w_sel_word = bus.I0;
            3'd1: w_sel_word = bus.I1;
            3'd2: w_sel_word = bus.I2;
            3'd3: w_sel_word = bus.I3;
            3'd4: w_sel_word = bus.I4;
            3'd5: w_sel_word = bus.I5;
            3'd6: w_sel_word = bus.I6;
            3'd7: w_sel_word = bus.I7;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_o <= {WIDTH{1'b0}};
        end else begin
            r_o <= w_sel_word;
        end
    end

    assign bus.o = r_o;

endmodule

`default_nettype wire

// File: tb/tb_mux8t1_32.sv
//------------------------------------------------------------------------------
// Module : tb_mux8t1_32
// Brief  : Self-checking bench for mux8t1_32 against an array-indexed model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux8t1_32;

    localparam int c_WIDTH = 32;

    logic               clk;
    logic               rst;
    logic [c_WIDTH-1:0] din [8];
    logic [2:0]         sel;

    int n_checks;
    int n_pass;

    mux8t1_32_if #(.WIDTH(c_WIDTH)) bus ();

    assign bus.I0 = din[0];
    assign bus.I1 = din[1];
    assign bus.I2 = din[2];
    assign bus.I3 = din[3];
    assign bus.I4 = din[4];
    assign bus.I5 = din[5];
    assign bus.I6 = din[6];
    assign bus.I7 = din[7];
    assign bus.s  = sel;

    mux8t1_32 #(.WIDTH(c_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [c_WIDTH-1:0] got,
                         input logic [c_WIDTH-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model: the word indexed by the select code present at the edge, or zero under reset.
    task automatic cycle(input string tag);
        logic [c_WIDTH-1:0] exp;
        exp = rst ? '0 : din[sel];
        @(posedge clk);
        #1;
        check(tag, bus.o, exp);
    endtask

    initial begin
        logic [2:0] b2b [4];
        b2b[0] = 3'd2; b2b[1] = 3'd7; b2b[2] = 3'd0; b2b[3] = 3'd4;
        n_checks = 0;
        n_pass   = 0;

        for (int i = 0; i < 8; i++) begin
            din[i] = ((i % 2 == 0) ? 32'hAA55_0000 : 32'h55AA_0000) | (32'h1111 * i);
        end

        // Reset held two cycles while I5 is selected
        rst = 1'b1;
        sel = 3'd5;
        cycle("reset0");
        cycle("reset1");
        rst = 1'b0;
        cycle("reset_release");
        check("reset_release_const", bus.o, 32'h55AA_5555);

        // Full sweep, several cycles per code
        for (int k = 0; k < 8; k++) begin
            sel = 3'(k);
            for (int r = 0; r < 3; r++) cycle($sformatf("sweep_s%0d", k));
        end
        check("sweep_s7_const", bus.o, 32'h55AA_7777);

        // Wrap from 7 back to 0
        sel = 3'd0;
        cycle("wrap");
        check("wrap_const", bus.o, 32'hAA55_0000);

        // Data tracking on the selected input, then a change on an unselected one
        sel = 3'd3;
        cycle("track_pre");
        din[3] = 32'hFFFF_FFFF;
        cycle("track_new");
        check("track_const", bus.o, 32'hFFFF_FFFF);
        din[2] = 32'h1234_5678;
        cycle("track_other");
        check("track_other_const", bus.o, 32'hFFFF_FFFF);

        // Back-to-back selects, then again with a one-cycle reset mid-stream
        din[2] = 32'hAA55_2222;
        din[3] = 32'h55AA_3333;
        for (int k = 0; k < 4; k++) begin
            sel = b2b[k];
            cycle($sformatf("b2b_%0d", k));
        end
        for (int k = 0; k < 4; k++) begin
            sel = b2b[k];
            rst = (k == 2);
            cycle($sformatf("b2b_rst_%0d", k));
        end
        rst = 1'b0;
        cycle("b2b_resume");
        check("b2b_resume_const", bus.o, 32'hAA55_4444);

        // Randomized data, select and occasional reset
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 8; i++) din[i] = $urandom;
            sel = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 15) == 0);
            cycle("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mux8t1_32.md
# mux8t1_32

Eight-way, 32-bit word selector with a registered output. One of eight data words I0..I7 is chosen by a 3-bit select `s` and presented on `o` after one clock edge. Used in the datapath wherever one of several 32-bit sources (register file ports, ALU results, immediates, constants) must be steered to a single destination bus.

## Interface
Parameters:
- WIDTH, default 32, bit width of each data input and of the output.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high; one clock, no other clocks.
- I0   input  WIDTH  data word selected when s = 3'd0.
- I1   input  WIDTH  data word selected when s = 3'd1.
- I2   input  WIDTH  data word selected when s = 3'd2.
- I3   input  WIDTH  data word selected when s = 3'd3.
- I4   input  WIDTH  data word selected when s = 3'd4.
- I5   input  WIDTH  data word selected when s = 3'd5.
- I6   input  WIDTH  data word selected when s = 3'd6.
- I7   input  WIDTH  data word selected when s = 3'd7.
- s    input  3      select code, unsigned, 0..7.
- o    output WIDTH  registered selected word.

## Operation
- Combinational selection: sel_word = I[s], where the index is the unsigned value of s; all 8 codes are valid and decode to exactly one input.
- No default or "don't care" case: every code maps to its input.
- Selection is bitwise: every bit of o comes from the same input word; no mixing across inputs, no masking, no sign or zero extension (all inputs are exactly WIDTH bits).
- Output register: on each rising edge of clk, o <= sel_word, unless rst is high.
- Reset: when rst = 1 at a rising edge, o <= {WIDTH{1'b0}}; rst takes priority over any select or data change in the same cycle.
- No enable or hold. o is reloaded every non-reset cycle.
- X or Z on s is not a legal operating condition. The implementation does not have to propagate it, and the verification bench must not drive it.

## Timing
- Latency: 1 clock. The values of s and I0..I7 sampled at rising edge N appear on o immediately after edge N.
- Throughput: a new selection every cycle. Back-to-back select changes each yield their own result one cycle later.
- o is glitch-free between edges; it changes only at rising edges of clk.
- Reset value of o: 0x00000000, valid after the first rising edge with rst = 1.
- Power-up value of o before any reset is undefined.
- Reset mid-operation: asserting rst forces o to 0 at the next edge, regardless of s. The first edge after rst deasserts loads the current selection.
- Simultaneous change of s and the selected data in the same cycle: o reflects both new values after the next edge.
- Wrap-around: s stepping from 7 back to 0 selects I0 with no special handling.
- Combinational path from s and I0..I7 to the register D input must meet one clock period. There is no path from any input to o that bypasses the register.

## Test plan
- Reset: hold rst = 1 for 2 cycles with s = 5 and I5 = 0x55AA5555 -> o = 0x00000000. Deassert rst -> o = 0x55AA5555 after the next edge.
- Full sweep: I0..I7 = 0xAA550000, 0x55AA1111, 0xAA552222, 0x55AA3333, 0xAA554444, 0x55AA5555, 0xAA556666, 0x55AA7777. Step s through 0,1,...,7, holding each value for several cycles -> one cycle after each step, o equals the matching word (for example, s = 6 gives 0xAA556666).
- Wrap: after s = 7 (o = 0x55AA7777), set s = 0 -> o = 0xAA550000 one cycle later.
- Data tracking: hold s = 3 and change I3 from 0x55AA3333 to 0xFFFFFFFF -> o = 0xFFFFFFFF one cycle later. Changing any other input (for example, I2 = 0x12345678) leaves o unchanged.
- Back-to-back selects: change s every cycle in the order 2,7,0,4 -> o over the next four cycles is 0xAA552222, 0x55AA7777, 0xAA550000, 0xAA554444.
- Reset mid-stream: during the back-to-back sequence, assert rst for one cycle -> o = 0 for that cycle, then resumes with the current selection.
